ddr3_rd_checker: RTL
====================

DDR3_RD_CHECKER -- requirements
Module: ddr3_rd_checker

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, default 29, app address width; APP_DATA_WIDTH, default 256, read beat width; FIFO_DEPTH, default 16, outstanding-read address slots (power of two).
REQ-002 Ports SHALL be:
- clk  in  1  user clock (DDR IP clk_out).
- rst_n  in  1  reset.
- init_calib_complete  in  1  DDR IP calibration done.
- start  in  1  one-cycle pulse that arms a check run.
- num_reads  in  16  read beats expected per run, latched on start.
- cmd_ready  in  1  IP command accept.
- cmd_en  in  1  command valid.
- cmd  in  3  command code.
- addr  in  ADDR_WIDTH  command address.
- rd_data_valid  in  1  read beat valid.
- rd_data  in  APP_DATA_WIDTH  read beat.
- busy  out  1  run in progress.
- done  out  1  run complete.
- pass  out  1  done with zero errors.
- err  out  1  sticky any-error flag.
- proto_err  out  1  sticky FIFO overflow or orphan beat.
- err_cnt  out  16  mismatching beats, saturating.
- first_err_addr  out  ADDR_WIDTH  address of first failing beat.
REQ-003 The block SHALL use one clock, clk; reset rst_n SHALL be synchronous and active-low.

Function
REQ-004 The FSM SHALL have states IDLE, WAIT_CAL, RUN, DONE.
REQ-005 IDLE or DONE + start SHALL clear counters and flags and latch num_reads, then enter RUN if init_calib_complete=1, else WAIT_CAL; start in WAIT_CAL/RUN SHALL be ignored.
REQ-006 WAIT_CAL SHALL enter RUN on the first cycle with init_calib_complete=1.
REQ-007 In RUN, a read SHALL be accepted when cmd_en & cmd_ready & cmd==3'b001, and addr SHALL be pushed into the address FIFO; write commands SHALL be ignored.
REQ-008 Each rd_data_valid beat in RUN SHALL pop one address; expected word i (i=0..APP_DATA_WIDTH/32-1) SHALL be {i[2:0], addr[28:0]}.
REQ-009 The comparison SHALL be registered: err, err_cnt and first_err_addr SHALL update exactly 1 cycle after the beat.
REQ-010 One mismatching beat SHALL add 1 to err_cnt regardless of how many words differ; err_cnt SHALL saturate at 16'hFFFF.
REQ-011 first_err_addr SHALL capture only the first mismatch of a run and then hold.
REQ-012 A push while full SHALL be dropped and SHALL set proto_err; push+pop on the same cycle while full SHALL succeed with count unchanged.
REQ-013 A beat with the FIFO empty SHALL set proto_err and err and increment err_cnt; there SHALL be no same-cycle push-to-pop bypass.
REQ-014 After num_reads beats have been checked, the FSM SHALL enter DONE in the same cycle that the last compare result becomes visible.
REQ-015 num_reads=0 SHALL enter DONE one cycle after RUN is entered.
REQ-016 busy SHALL equal (state==WAIT_CAL|RUN); done SHALL equal (state==DONE); pass SHALL equal done & ~err & ~proto_err.
REQ-017 rd_data_valid outside RUN SHALL be ignored.

Reset
REQ-018 rst_n=0 at a clk edge SHALL force IDLE, empty the FIFO, and zero all outputs, including first_err_addr; this SHALL also apply mid-run.

Configuration
REQ-019 Macro DDR_CHK_CAPTURE_EN defined: output ports cap_data and cap_exp (APP_DATA_WIDTH each) SHALL hold the first failing beat and its expected value, cleared on start and on reset.
REQ-020 Without DDR_CHK_CAPTURE_EN: these ports and their registers SHALL not exist, and all other behaviour SHALL be unchanged.

Structure
REQ-021 Package ddr3_chk_pkg SHALL hold the state enum, the CMD_RD=3'b001 and CMD_WR=3'b000 constants, and the expected-beat function.
REQ-022 The address FIFO SHALL be sub-module ddr3_chk_addr_fifo (synchronous, full/empty/count outputs).

Verification
REQ-023 start, num_reads=4, 4 reads at 0x0/0x8/0x10/0x18 with correct data -> done after the 4th beat +1 cycle, pass=1, err_cnt=0.
REQ-024 Same as REQ-023 with word 3 of the 2nd beat corrupted -> err_cnt=1, first_err_addr=0x8, pass=0.
REQ-025 17 reads accepted with no returns (FIFO_DEPTH=16) -> proto_err=1; then 16 correct beats -> err_cnt=0.
REQ-026 rd_data_valid with the FIFO empty in RUN -> proto_err=1, err_cnt=1; the same beat in IDLE -> no change.
REQ-027 start with init_calib_complete=0 -> state WAIT_CAL, busy=1; a read command before calibration -> not pushed; rst_n=0 mid-RUN -> all outputs 0 next cycle.

Source files
------------

// File: rtl/ddr3_chk_pkg.sv
// Shared types and helpers for the DDR3 read-data checker.
// The expected read pattern is a per-word tag: each 32-bit word of a beat
// carries its word index in the top three bits and the 29-bit command
// address in the rest.
package ddr3_chk_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_CAL = 2'd1,
        RUN      = 2'd2,
        DONE     = 2'd3
    } state_e;

    localparam logic [2:0] CMD_RD = 3'b001;
    localparam logic [2:0] CMD_WR = 3'b000;

    localparam int WORD_W     = 32;
    localparam int EXP_ADDR_W = 29;

    // One expected 32-bit word of a beat: word index on top, address below.
    function automatic logic [WORD_W-1:0] exp_word(input logic [2:0]            idx,
                                                   input logic [EXP_ADDR_W-1:0] a);
        return {idx, a};
    endfunction

    // 16-bit increment that sticks at all-ones.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/ddr3_chk_addr_fifo.sv
// Address FIFO for outstanding reads. Head is presented combinationally so
// the returning beat can be compared in the same cycle it is popped.
// A push while full is only accepted if a pop happens on the same cycle.
module ddr3_chk_addr_fifo #(
    parameter int WIDTH = 29,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         din_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      cnt_q, cnt_d;
    logic             wr_ok, rd_ok;

    assign full_o  = (cnt_q == (PW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign dout_o  = mem_q[rd_ptr_q];

    assign wr_ok = push_i & (~full_o | pop_i);
    assign rd_ok = pop_i & ~empty_o;

    // Pointer and occupancy next-state; clear empties the FIFO outright.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (wr_ok) wr_ptr_d = wr_ptr_q + PW'(1);
            if (rd_ok) rd_ptr_d = rd_ptr_q + PW'(1);
            case ({wr_ok, rd_ok})
                2'b10:   cnt_d = cnt_q + (PW+1)'(1);
                2'b01:   cnt_d = cnt_q - (PW+1)'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Control registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (wr_ok && !clr_i) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/ddr3_rd_checker.sv
// DDR3 read-data checker: snoops read commands into an address FIFO, pops
// one address per returning beat and compares the beat against the
// address-derived pattern. Error results land one cycle after the beat.
// Optional capture of the first failing beat: define DDR_CHK_CAPTURE_EN.
module ddr3_rd_checker
    import ddr3_chk_pkg::*;
#(
    parameter int ADDR_WIDTH     = 29,
    parameter int APP_DATA_WIDTH = 256,
    parameter int FIFO_DEPTH     = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      init_calib_complete,
    input  logic                      start,
    input  logic [15:0]               num_reads,
    input  logic                      cmd_ready,
    input  logic                      cmd_en,
    input  logic [2:0]                cmd,
    input  logic [ADDR_WIDTH-1:0]     addr,
    input  logic                      rd_data_valid,
    input  logic [APP_DATA_WIDTH-1:0] rd_data,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic                      err,
    output logic                      proto_err,
    output logic [15:0]               err_cnt,
    output logic [ADDR_WIDTH-1:0]     first_err_addr
`ifdef DDR_CHK_CAPTURE_EN
    ,
    output logic [APP_DATA_WIDTH-1:0] cap_data,
    output logic [APP_DATA_WIDTH-1:0] cap_exp
`endif
);

    localparam int NWORDS = APP_DATA_WIDTH / WORD_W;

    state_e                  state_q, state_d;
    logic [15:0]             num_q, num_d;
    logic [15:0]             beats_q, beats_d;
    logic [15:0]             cnt_q, cnt_d;
    logic                    err_q, err_d;
    logic                    proto_q, proto_d;
    logic                    have_first_q, have_first_d;
    logic [ADDR_WIDTH-1:0]   first_q, first_d;

    logic                    fifo_full, fifo_empty;
    logic [ADDR_WIDTH-1:0]   fifo_head;
    logic [$clog2(FIFO_DEPTH):0] fifo_cnt;
    logic                    unused_fifo_cnt;

    logic                    run, start_ok, rd_cmd, beat, pop, orphan, overflow;
    logic                    mismatch, last_beat;
    logic [EXP_ADDR_W-1:0]   head_a29;
    logic [APP_DATA_WIDTH-1:0] exp_beat;

    assign run      = (state_q == RUN);
    assign start_ok = start & ((state_q == IDLE) | (state_q == DONE));
    assign rd_cmd   = run & cmd_en & cmd_ready & (cmd == CMD_RD);
    assign beat     = run & rd_data_valid;
    assign pop      = beat & ~fifo_empty;
    assign orphan   = beat & fifo_empty;
    assign overflow = rd_cmd & fifo_full & ~pop;

    // Occupancy is exposed by the FIFO for debug; the checker only needs full/empty.
    assign unused_fifo_cnt = ^fifo_cnt;

    ddr3_chk_addr_fifo #(
        .WIDTH (ADDR_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_addr_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (start_ok),
        .push_i  (rd_cmd),
        .din_i   (addr),
        .pop_i   (pop),
        .dout_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    // The pattern is defined on a 29-bit address; adapt other widths.
    if (ADDR_WIDTH >= EXP_ADDR_W) begin : g_a29_trunc
        assign head_a29 = fifo_head[EXP_ADDR_W-1:0];
    end else begin : g_a29_ext
        assign head_a29 = {{(EXP_ADDR_W-ADDR_WIDTH){1'b0}}, fifo_head};
    end

    for (genvar g = 0; g < NWORDS; g++) begin : g_exp
        assign exp_beat[g*WORD_W +: WORD_W] = exp_word(3'(g), head_a29);
    end

    // Any differing word makes the whole beat count as one mismatch.
    assign mismatch  = pop & (rd_data != exp_beat);
    assign last_beat = beat & (({1'b0, beats_q} + 17'd1) == {1'b0, num_q});

    // Run-control FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (start) state_d = init_calib_complete ? RUN : WAIT_CAL;
            WAIT_CAL:   if (init_calib_complete) state_d = RUN;
            RUN:        if ((num_q == 16'd0) || last_beat) state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    // Run bookkeeping and error flags next state.
    always_comb begin
        num_d        = num_q;
        beats_d      = beats_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        proto_d      = proto_q;
        have_first_d = have_first_q;
        first_d      = first_q;
        if (start_ok) begin
            num_d        = num_reads;
            beats_d      = '0;
            cnt_d        = '0;
            err_d        = 1'b0;
            proto_d      = 1'b0;
            have_first_d = 1'b0;
            first_d      = '0;
        end else if (run) begin
            if (beat) beats_d = beats_q + 16'd1;
            if (mismatch | orphan) begin
                err_d = 1'b1;
                cnt_d = sat_inc16(cnt_q);
            end
            if (orphan | overflow) proto_d = 1'b1;
            if (mismatch && !have_first_q) begin
                have_first_d = 1'b1;
                first_d      = fifo_head;
            end
        end
    end

    // State and bookkeeping registers; reset clears everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            num_q        <= '0;
            beats_q      <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            proto_q      <= 1'b0;
            have_first_q <= 1'b0;
            first_q      <= '0;
        end else begin
            state_q      <= state_d;
            num_q        <= num_d;
            beats_q      <= beats_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            proto_q      <= proto_d;
            have_first_q <= have_first_d;
            first_q      <= first_d;
        end
    end

`ifdef DDR_CHK_CAPTURE_EN
    logic [APP_DATA_WIDTH-1:0] cap_data_q, cap_exp_q;

    // Hold the first failing beat and the pattern it was compared against.
    always_ff @(posedge clk) begin
        if (!rst_n || start_ok) begin
            cap_data_q <= '0;
            cap_exp_q  <= '0;
        end else if (mismatch && !have_first_q) begin
            cap_data_q <= rd_data;
            cap_exp_q  <= exp_beat;
        end
    end

    assign cap_data = cap_data_q;
    assign cap_exp  = cap_exp_q;
`endif

    assign busy           = (state_q == WAIT_CAL) | (state_q == RUN);
    assign done           = (state_q == DONE);
    assign pass           = done & ~err_q & ~proto_q;
    assign err            = err_q;
    assign proto_err      = proto_q;
    assign err_cnt        = cnt_q;
    assign first_err_addr = first_q;

endmodule
